zero_fetch_unit: RTL and testbench

Parametrised instruction-fetch unit for the next-generation zerocore. It replaces the fixed "PC drives the RAM address, take bits [31:0]" fetch path with the following:
- a request/response memory handshake;
- correct lane selection of 32-bit instructions within a wide RAM word;
- a small prefetch FIFO toward decode;
- a redirect input for branches and jumps that flushes stale instructions.

It sits between the instruction RAM port and `id_stage`.

---
 rtl/zero_fetch_unit_pkg.sv | 13 +
 rtl/zero_fetch_fifo.sv | 49 ++++
 rtl/zero_fetch_unit.sv | 115 +++++++++++
 tb/tb_zero_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zero_fetch_unit_pkg.sv
// Shared definitions for the zerocore fetch path: instruction width, reset PC and fetch FSM states.
package zero_fetch_unit_pkg;

    localparam int INST_BUS = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/zero_fetch_fifo.sv
// Synchronous prefetch FIFO; push data visible at the head one cycle later, flush wins over push/pop.
// No internal backpressure: the producer must respect the count output and never push when full.
module zero_fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/zero_fetch_unit.sv
// Instruction fetch: one outstanding RAM request, lane select into a prefetch FIFO; RAM->decode 2 cycles.
// Requests are credit-gated on FIFO occupancy; redirect flushes the FIFO and drops any stale response.
module zero_fetch_unit
    import zero_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W     = 64,
    parameter int              DATA_W     = 64,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_BUS-1:0] inst,
    output logic [ADDR_W-1:0]   inst_pc,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc
);

    localparam int OFF_W   = $clog2(DATA_W / 8);
    localparam int LANES   = DATA_W / 32;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INST_BUS;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(DATA_W / 8 - 1);
    localparam logic [ADDR_W-1:0] INST_MASK = ~ADDR_W'(3);

    fetch_state_t         state;
    logic [ADDR_W-1:0]    fetch_pc;
    logic [ADDR_W-1:0]    inflight_pc;
    logic [CNT_W-1:0]     fifo_count;
    logic [ENTRY_W-1:0]   head_dat;
    logic [INST_BUS-1:0]  lane;
    logic                 outstanding;
    logic                 credit;
    logic                 req_fire;
    logic                 push;
    logic                 pop;

    // Outstanding request holds a FIFO slot until its response lands or is dropped.
    assign outstanding = (state != S_REQ);
    assign credit = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);

    assign mem_req_valid = (state == S_REQ) && credit && !redirect_valid && !rst;
    assign mem_req_addr  = fetch_pc & WORD_MASK;
    assign req_fire      = mem_req_valid && mem_req_ready;

    generate
        if (LANES == 1) begin : g_one_lane
            assign lane = mem_rsp_data[INST_BUS-1:0];
        end else begin : g_lane_mux
            logic [OFF_W-3:0] k;
            assign k    = inflight_pc[OFF_W-1:2];
            assign lane = mem_rsp_data[{k, 5'b0} +: INST_BUS];
        end
    endgenerate

    assign push       = (state == S_WAIT) && mem_rsp_valid && !redirect_valid;
    assign inst_valid = (fifo_count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & INST_MASK;
            case (state)
                // A response landing in the redirect cycle retires the outstanding request.
                S_WAIT, S_DROP: state <= mem_rsp_valid ? S_REQ : S_DROP;
                default:        state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        inflight_pc <= fetch_pc;
                        fetch_pc    <= fetch_pc + ADDR_W'(4);
                        state       <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (mem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    zero_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({inflight_pc, lane}),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign inst_pc = head_dat[ENTRY_W-1:INST_BUS];
    assign inst    = head_dat[INST_BUS-1:0];

endmodule

// File: tb/tb_zero_fetch_unit.sv
// Directed plus randomized bench for zero_fetch_unit against a program-order PC stream model.
module tb_zero_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    zero_fetch_unit #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .FIFO_DEPTH (4),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Stimulus controls
    bit          ram_rdy = 1'b1, dec_rdy = 1'b1;
    bit          rnd_rdy = 1'b0, rnd_dec = 1'b0, rnd_lat = 1'b0;
    int          lat = 1;
    bit          redir_en = 1'b0;
    logic [63:0] redir_pc = '0;
    bit          junk_rsp = 1'b0;

    // RAM model and reference state
    bit          pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int          delay = 0;
    logic [63:0] exp_pc = RST_PC;
    int          cyc = 0;
    int          n_pops = 0;
    bit          last_acc;
    logic        obs_req_vld, obs_inst_vld;
    logic [63:0] obs_req_addr;

    logic [63:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [63:0] pop_pc_q[$];
    int          pop_cyc_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Program image: every 32-bit slot holds a distinct value derived from its address.
    function automatic logic [31:0] inst_of(input logic [63:0] p);
        return ((p[31:0] ^ p[63:32]) * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    function automatic logic [63:0] word_of(input logic [63:0] a);
        return {inst_of(a + 64'd4), inst_of(a)};
    endfunction

    task automatic clear_logs();
        req_addr_q.delete();
        req_cyc_q.delete();
        pop_pc_q.delete();
        pop_cyc_q.delete();
    endtask

    // One clock: drive at negedge, observe 1ns later, then advance to the next negedge.
    task automatic cycle();
        mem_req_ready  = rnd_rdy ? ($urandom_range(0, 3) != 0) : ram_rdy;
        inst_ready     = rnd_dec ? ($urandom_range(0, 2) != 0) : dec_rdy;
        redirect_valid = redir_en;
        redirect_pc    = redir_pc;
        if (junk_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        end else begin
            mem_rsp_valid = pend && (delay == 0);
            mem_rsp_data  = mem_rsp_valid ? word_of(pend_addr) : '0;
        end
        #1;
        obs_req_vld  = mem_req_valid;
        obs_req_addr = mem_req_addr;
        obs_inst_vld = inst_valid;
        last_acc     = mem_req_valid && mem_req_ready;
        if (redirect_valid) chk("inst_valid_during_redirect", 64'(inst_valid), 64'd0);
        if (mem_req_valid) chk("req_addr_aligned", mem_req_addr & 64'h7, 64'd0);
        if (inst_valid && inst_ready) begin
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_inst", 64'(inst), 64'(inst_of(exp_pc)));
            pop_pc_q.push_back(inst_pc);
            pop_cyc_q.push_back(cyc);
            exp_pc = exp_pc + 64'd4;
            n_pops++;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
        if (mem_rsp_valid && !junk_rsp) pend = 1'b0;
        else if (pend && delay > 0) delay--;
        if (last_acc) begin
            pend      = 1'b1;
            pend_addr = mem_req_addr;
            delay     = rnd_lat ? int'($urandom_range(0, 2)) : lat - 1;
            req_addr_q.push_back(mem_req_addr);
            req_cyc_q.push_back(cyc);
        end
        redir_en = 1'b0;
        junk_rsp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_req_addr", mem_req_addr, RST_PC);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst    = 1'b0;
        pend   = 1'b0;
        exp_pc = RST_PC;
    endtask

    task automatic wait_acc();
        int i = 0;
        do begin
            cycle();
            i++;
        end while (!last_acc && i < 30);
        chk("wait_acc", 64'(last_acc), 64'd1);
    endtask

    initial begin
        int c0, r;
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk);

        // 1: reset release, 1-cycle RAM, lane order and latency
        ram_rdy = 1; dec_rdy = 1; lat = 1;
        do_reset();
        clear_logs();
        c0 = cyc;
        repeat (8) cycle();
        chk("t1_nreq", 64'(req_addr_q.size() >= 3), 64'd1);
        chk("t1_req0", req_addr_q[0], RST_PC);
        chk("t1_req1", req_addr_q[1], RST_PC);
        chk("t1_req2", req_addr_q[2], RST_PC + 64'd8);
        chk("t1_first_req_cycle", 64'(req_cyc_q[0]), 64'(c0));
        chk("t1_latency", 64'(pop_cyc_q[0] - req_cyc_q[0]), 64'd2);
        chk("t1_req_spacing", 64'(req_cyc_q[1] - req_cyc_q[0]), 64'd2);
        chk("t1_pop0", pop_pc_q[0], RST_PC);
        chk("t1_pop1", pop_pc_q[1], RST_PC + 64'd4);

        // 2: decode stalled, credit limits to FIFO depth, then drain in order
        dec_rdy = 0;
        redir_en = 1; redir_pc = 64'h8000_1000;
        cycle();
        clear_logs();
        repeat (20) cycle();
        chk("t2_nreq_stalled", 64'(req_addr_q.size()), 64'd4);
        chk("t2_req_valid_full", 64'(obs_req_vld), 64'd0);
        dec_rdy = 1;
        clear_logs();
        repeat (12) cycle();
        chk("t2_drain0", pop_pc_q[0], 64'h8000_1000);
        chk("t2_drain3", pop_pc_q[3], 64'h8000_100C);
        chk("t2_resumed", 64'(req_addr_q.size() > 0), 64'd1);

        // 3: redirect during S_WAIT with a 3-cycle RAM
        lat = 3;
        wait_acc();
        r = cyc;
        redir_en = 1; redir_pc = 64'h8000_0102;
        cycle();
        clear_logs();
        repeat (15) cycle();
        chk("t3_req_addr", req_addr_q[0], 64'h8000_0100);
        chk("t3_req_after_drop", 64'(req_cyc_q[0]), 64'(r + 3));
        chk("t3_first_pc", pop_pc_q[0], 64'h8000_0100);

        // 4a: redirect coincident with a response
        lat = 1; dec_rdy = 0;
        wait_acc();
        redir_en = 1; redir_pc = 64'h8000_2000;
        cycle();
        ram_rdy = 0;
        cycle();
        chk("t4a_inst_valid", 64'(obs_inst_vld), 64'd0);
        chk("t4a_req_valid", 64'(obs_req_vld), 64'd1);
        chk("t4a_req_addr", obs_req_addr, 64'h8000_2000);

        // 4b: redirect while a full FIFO would pop
        ram_rdy = 1;
        repeat (12) cycle();
        chk("t4b_full_no_req", 64'(obs_req_vld), 64'd0);
        chk("t4b_full_valid", 64'(obs_inst_vld), 64'd1);
        dec_rdy = 1;
        redir_en = 1; redir_pc = 64'h8000_3000;
        cycle();
        ram_rdy = 0;
        cycle();
        chk("t4b_inst_valid", 64'(obs_inst_vld), 64'd0);

        // 5: RAM not ready for 5 cycles after reset
        do_reset();
        clear_logs();
        repeat (5) begin
            cycle();
            chk("t5_req_valid_held", 64'(obs_req_vld), 64'd1);
            chk("t5_req_addr_held", obs_req_addr, RST_PC);
        end
        chk("t5_no_accept", 64'(req_addr_q.size()), 64'd0);
        ram_rdy = 1;
        cycle();
        ram_rdy = 0;
        chk("t5_one_accept", 64'(req_addr_q.size()), 64'd1);
        cycle();
        cycle();
        chk("t5_addr_after_one", obs_req_addr, RST_PC);
        ram_rdy = 1;
        cycle();
        ram_rdy = 0;
        cycle();
        cycle();
        chk("t5_addr_after_two", obs_req_addr, RST_PC + 64'd8);

        // 6: reset during S_WAIT, late response afterwards
        ram_rdy = 1; lat = 3;
        wait_acc();
        do_reset();
        ram_rdy = 0;
        junk_rsp = 1;
        cycle();
        chk("t6_req_addr", obs_req_addr, RST_PC);
        cycle();
        chk("t6_no_push", 64'(obs_inst_vld), 64'd0);
        ram_rdy = 1;
        clear_logs();
        repeat (8) cycle();
        chk("t6_first_req", req_addr_q[0], RST_PC);

        // 7: PC wraps past the top of the address space
        lat = 1;
        redir_en = 1; redir_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        cycle();
        clear_logs();
        repeat (14) cycle();
        chk("t7_pc_top", pop_pc_q[1], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t7_pc_wrap", pop_pc_q[2], 64'd0);

        // Random traffic: ready, latency and redirects all randomized
        rnd_rdy = 1; rnd_dec = 1; rnd_lat = 1;
        c0 = n_pops;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                redir_en = 1;
                redir_pc = {32'h0, 16'h8000, 16'($urandom)};
            end
            cycle();
        end
        chk("rand_progress", 64'(n_pops - c0 > 200), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
